// File: rtl/ip_msxbus_vdp_bridge.sv
// Bridges the asynchronous MSX cartridge bus onto the VDP req/ack register port.
// Optional MSXBUS_WRITE_FIFO_EN: queue writes in a 2^FIFO_DEPTH_LOG2-entry FIFO instead of stalling on them.
module ip_msxbus_vdp_bridge #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_ce,
  input  logic       n_trd,
  input  logic       n_twr,
  input  logic [1:0] ta,
  input  logic [7:0] td_in,
  output logic [7:0] td_out,
  output logic       tdir,
  output logic       twait,
  output logic       req,
  input  logic       ack,
  output logic       wr,
  output logic [1:0] address,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  typedef enum logic [2:0] {IDLE, WR_FULL, RD_DRAIN, RD_REQ, RD_DRIVE, WAIT_END} state_t;

  state_t      state, state_nxt;
  logic [2:0]  strb_p0, strb_p1;
  logic [9:0]  dat_p0, dat_p1;
  logic        ce_s, rd_s, wr_s;
  logic [1:0]  ta_s;
  logic [7:0]  td_s;
  logic        rd_act_p2, wr_act_p2, act_p3;
  logic        start;
  logic [1:0]  rd_ta, rd_ta_nxt;
  logic [7:0]  td_out_nxt, wdata_nxt;
  logic [1:0]  address_nxt;
  logic        tdir_nxt, twait_nxt, req_nxt, wr_nxt;
  logic        fifo_empty;

  assign {ce_s, rd_s, wr_s} = strb_p1;
  assign {ta_s, td_s}       = dat_p1;
  assign start              = (rd_act_p2 | wr_act_p2) & ~act_p3;

  // Stages 0-1 synchronise, stage 2 decodes the access, stage 3 holds it for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_p0   <= 3'b111;
      strb_p1   <= 3'b111;
      rd_act_p2 <= 1'b0;
      wr_act_p2 <= 1'b0;
      act_p3    <= 1'b0;
    end else begin
      strb_p0   <= {n_ce, n_trd, n_twr};
      strb_p1   <= strb_p0;
      rd_act_p2 <= ~ce_s & ~rd_s;
      wr_act_p2 <= ~ce_s & ~wr_s;
      act_p3    <= rd_act_p2 | wr_act_p2;
    end
  end

  always_ff @(posedge clk) begin
    dat_p0 <= {ta, td_in};
    dat_p1 <= dat_p0;
  end

`ifdef MSXBUS_WRITE_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = 1;

  logic [9:0]               fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                     fifo_full, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                      (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

  // The head entry stays queued until its ack, so a full FIFO includes the write in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {ta_s, td_s};
  end
`else
  assign fifo_empty = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    td_out_nxt  = td_out;
    tdir_nxt    = tdir;
    twait_nxt   = twait;
    req_nxt     = req;
    wr_nxt      = wr;
    address_nxt = address;
    wdata_nxt   = wdata;
    rd_ta_nxt   = rd_ta;
`ifdef MSXBUS_WRITE_FIFO_EN
    push = 1'b0;
    pop  = 1'b0;
`endif

    if (req && ack) begin
      req_nxt = 1'b0;
`ifdef MSXBUS_WRITE_FIFO_EN
      pop = wr;
    end else if (!req && !fifo_empty && state != RD_REQ) begin
      req_nxt = 1'b1;
      wr_nxt  = 1'b1;
      {address_nxt, wdata_nxt} = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
`endif
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (rd_act_p2) begin
            twait_nxt = 1'b1;
            rd_ta_nxt = ta_s;
            if (fifo_empty && !req) begin
              req_nxt     = 1'b1;
              wr_nxt      = 1'b0;
              address_nxt = ta_s;
              state_nxt   = RD_REQ;
            end else begin
              state_nxt = RD_DRAIN;
            end
          end else begin
`ifdef MSXBUS_WRITE_FIFO_EN
            if (!fifo_full) begin
              push      = 1'b1;
              state_nxt = WAIT_END;
            end else begin
              twait_nxt = 1'b1;
              state_nxt = WR_FULL;
            end
`else
            twait_nxt   = 1'b1;
            req_nxt     = 1'b1;
            wr_nxt      = 1'b1;
            address_nxt = ta_s;
            wdata_nxt   = td_s;
            state_nxt   = RD_REQ;
`endif
          end
        end
      end
      WR_FULL: begin
`ifdef MSXBUS_WRITE_FIFO_EN
        if (!fifo_full) begin
          push      = 1'b1;
          twait_nxt = 1'b0;
          state_nxt = WAIT_END;
        end
`endif
      end
      RD_DRAIN: begin
        if (fifo_empty && !req) begin
          req_nxt     = 1'b1;
          wr_nxt      = 1'b0;
          address_nxt = rd_ta;
          state_nxt   = RD_REQ;
        end
      end
      RD_REQ: begin
        // Without the FIFO, writes also wait here; wr tells the two apart
        if (req && ack) begin
          twait_nxt = 1'b0;
          if (wr) begin
            state_nxt = WAIT_END;
          end else begin
            td_out_nxt = rdata;
            tdir_nxt   = 1'b1;
            state_nxt  = RD_DRIVE;
          end
        end
      end
      RD_DRIVE: begin
        if (!rd_act_p2) begin
          tdir_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      WAIT_END: begin
        if (!rd_act_p2 && !wr_act_p2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      td_out  <= 8'h00;
      tdir    <= 1'b0;
      twait   <= 1'b0;
      req     <= 1'b0;
      wr      <= 1'b0;
      address <= 2'd0;
      wdata   <= 8'h00;
    end else begin
      state   <= state_nxt;
      td_out  <= td_out_nxt;
      tdir    <= tdir_nxt;
      twait   <= twait_nxt;
      req     <= req_nxt;
      wr      <= wr_nxt;
      address <= address_nxt;
      wdata   <= wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    rd_ta <= rd_ta_nxt;
  end

endmodule

// File: doc/ip_msxbus_vdp_bridge.md
# ip_msxbus_vdp_bridge

Bridges the asynchronous MSX cartridge bus (n_ce, n_trd, n_twr, ta, td) to the VDP request/ack register port (req, ack, wr, adr, dbo, dbi). It replaces the debugger as the VDP host port in the cartridge top. It synchronises bus strobes and decodes accesses. Writes are queued in a small FIFO; reads stall the Z80 via twait until the VDP answers.

## Interface
- FIFO_DEPTH_LOG2, 2, log2 of write FIFO depth (used only with MSXBUS_WRITE_FIFO_EN).
- clk  in  1  system clock (PLL clkout).
- reset  in  1  synchronous, active-high reset.
- n_ce  in  1  async cartridge chip enable, active-low.
- n_trd  in  1  async read strobe, active-low.
- n_twr  in  1  async write strobe, active-low.
- ta  in  2  async VDP register-port address.
- td_in  in  8  async bus data, as sampled from td.
- td_out  out  8  read data driven onto td when tdir=1.
- tdir  out  1  1 = drive td toward MSX.
- twait  out  1  1 = hold MSX in wait.
- req  out  1  VDP request.
- ack  in  1  VDP acknowledge, one-cycle pulse.
- wr  out  1  1 = write, 0 = read; valid while req=1.
- address  out  2  VDP port address; valid while req=1.
- wdata  out  8  VDP write data; valid while req=1.
- rdata  in  8  VDP read data; valid in the ack cycle.

## Operation
- Synchronisation: two-flop synchronisers on n_ce, n_trd, n_twr, ta, td_in, giving ce_s, rd_s, wr_s, ta_s, td_s.
- Access detection: rd_act = !ce_s & !rd_s; wr_act = !ce_s & !wr_s.
  - A start is the rising edge of (rd_act | wr_act) against its previous-cycle value.
  - If both strobes are low, the access is a read.
- FSM states: IDLE, WR_FULL, RD_DRAIN, RD_REQ, RD_DRIVE, WAIT_END.
- IDLE, write start:
  - If the FIFO is not full, push {ta_s, td_s} and go to WAIT_END.
  - If the FIFO is full, set twait=1 and go to WR_FULL.
- WR_FULL: push on the first cycle the FIFO is not full, set twait=0, go to WAIT_END.
- IDLE, read start: set twait=1.
  - Go to RD_REQ if the FIFO is empty and no request is outstanding; otherwise go to RD_DRAIN.
  - Reads never overtake queued writes.
- RD_DRAIN: wait until the FIFO is empty and the last write has been acked, then go to RD_REQ.
- RD_REQ: drive req=1, wr=0, address=ta latched at the start. On ack, latch rdata into td_out, set tdir=1 and twait=0, go to RD_DRIVE.
- RD_DRIVE: hold tdir=1 until rd_act=0, then set tdir=0 and go to IDLE.
- WAIT_END: go to IDLE once rd_act=0 and wr_act=0. This means one bus access yields exactly one transaction.
- FIFO issue:
  - When the FIFO is non-empty and req=0 (and the FSM is not in RD_REQ), pop the head into address/wdata, set wr=1, req=1.
  - Hold req until ack; the FIFO side can issue again from the cycle after ack.
- Handshake rules:
  - req rises only from 0; it is cleared in the cycle after ack is sampled.
  - wr, address and wdata are stable while req=1.
  - ack while req=0 is ignored.
- Reset: every output, the FSM and the FIFO pointers are cleared in the same edge. Outstanding requests are abandoned and a late ack is ignored.
- Reset values: td_out=0x00, tdir=0, twait=0, req=0, wr=0, address=0, wdata=0x00.

## Timing
- Strobe falling edge first sampled at edge k: the start is detected and registered outputs update at edge k+3.
- Read with an empty FIFO: twait=1 and req=1 at k+3. Ack at edge m gives td_out valid, tdir=1 and twait=0 at m+1; req=0 at m+1.
- Write with the FIFO not full: entry valid at k+3, req=1 at k+4 at the earliest, twait stays 0.
- Strobe release sampled at edge r: tdir=0 at r+3.
- FIFO throughput: one write per two cycles (req, ack) with a zero-latency VDP.

## Configuration
- MSXBUS_WRITE_FIFO_EN defined: 2^FIFO_DEPTH_LOG2-entry write FIFO as described.
- MSXBUS_WRITE_FIFO_EN undefined: no FIFO, and writes behave like reads for stalling.
  - A write start sets twait=1 and req=1, wr=1 with the latched ta/td.
  - On ack, twait=0 and the FSM goes to WAIT_END.
  - RD_DRAIN and WR_FULL are never entered.

## Test plan
- Write port 0 with 0x5A, ack one cycle after req -> one req with wr=1, address=0, wdata=0x5A; twait never asserts (FIFO build).
- Read port 1, ack 5 cycles after req with rdata=0x9F -> twait=1 from k+3 until ack+1; td_out=0x9F and tdir=1 at ack+1; tdir=0 three cycles after n_trd rises.
- Write 5 bytes 0x01..0x05 with ack held off -> first 4 queued, 5th sets twait=1 until a slot frees; VDP sees 0x01..0x05 in order.
- Write 0x11, 0x22, then read port 0 immediately -> read req issued only after both write acks; rdata returned correctly.
- Assert reset while req=1 in RD_REQ, then pulse ack -> all outputs at reset values next edge; ack ignored; FIFO empty.
- MSXBUS_WRITE_FIFO_EN undefined: write 0xC3 to port 2, ack after 4 cycles -> twait=1 from k+3 until ack+1; exactly one transaction.
